// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and width helpers for the UART receive path
//
// Purpose: state enumeration for uart_rx_ctrl plus constant functions that
// size the bit timer counter and the data bit index from module parameters.
// Ports: none (package).
package uart_pkg;

  // PARITY is always declared so the encoding does not change with the build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Bits needed to hold any value 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of the bit timer count: $clog2(CLKS_PER_BIT).
  function automatic int timer_width(input int clks_per_bit);
    return cnt_width(clks_per_bit);
  endfunction

  // Width of the data bit index: 0..DATA_BITS-1.
  function automatic int index_width(input int data_bits);
    return cnt_width(data_bits);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_bit_timer.sv
// rtl/uart_rx_ctrl_bit_timer.sv - restartable cycle timer used as the UART RX time base
//
// Purpose: counts clk cycles from 0 up to limit and pulses tick for one cycle
// when the count equals limit, then wraps to 0. restart forces the count back
// to 0 so the next tick comes limit+1 cycles later.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   restart - clear the count this cycle
//   limit   - terminal count (tick when count == limit)
//   tick    - one-cycle terminal count pulse
module bit_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: start detect, mid-bit sampling, framing checks
//
// Purpose: synchronises rx, detects the start edge, samples start/data/stop
// bits at mid-bit instants scheduled by bit_timer and presents each good word
// on data with a one-cycle valid strobe; a low stop bit gives frame_err.
// Optional feature macro: UART_RX_PARITY_EN adds an even parity bit between
// the data and stop bits and the parity_err output.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   rx         - asynchronous serial line, idles high
//   data       - last correctly framed word
//   valid      - one-cycle pulse when data updates
//   frame_err  - one-cycle pulse when the stop bit samples low
//   parity_err - one-cycle pulse on even parity mismatch (UART_RX_PARITY_EN only)
//   busy       - high while a frame is in progress
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW   = timer_width(CLKS_PER_BIT);
  localparam int IW   = index_width(DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] LIM_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] LIM_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  // Synchroniser and edge history; all idle high.
  logic rx_meta_q;
  logic rx_s_q;
  logic rx_prev_q;

  // sync_fill_q[1] marks that rx_s_q holds a real post-reset pin sample, so a
  // line that is low at reset release cannot look like a falling edge.
  logic [1:0] sync_fill_q;
  logic       armed_q;

  rx_state_t            state_q;
  logic [IW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q;
  logic                 par_bad_q;
`endif

  logic          fall;
  logic          tick;
  logic          restart;
  logic [CW-1:0] limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      sync_fill_q <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      armed_q     <= armed_q | (sync_fill_q[1] & rx_s_q);
    end
  end

  assign fall = armed_q & rx_prev_q & ~rx_s_q;

  // The timer restarts on leaving IDLE and on every sample tick, so each
  // sample lands a full limit+1 cycles after the previous state entry.
  assign restart = (state_q == IDLE) ? fall : tick;
  assign limit   = (state_q == START) ? LIM_HALF : LIM_BIT;

  bit_timer #(
    .W(CW)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .limit  (limit),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              // Start bit gone by mid-bit: a glitch, drop silently.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + IW'(1);
            if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            // Even parity: data bits plus parity bit must XOR to 0.
            par_bad_q <= ^{shift_q, rx_s_q};
            state_q   <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!rx_s_q) begin
              frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
`endif
            end else begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a pin-level reference decoder
module tb_uart_rx_ctrl;

  localparam int CLKS = 16;
  localparam int DB   = 8;
  localparam int HALF = CLKS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif
  // Pin-cycle offset of the stop sample from the falling edge of the start bit.
  localparam int STOP_OFF = HALF + (NB + 1) * CLKS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  bit            par_flip = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int base        = 0;
  int good_data   = 0;

  bit wave[$];
  int ev_kind[$], ev_cyc[$], ev_data[$], ev_busy[$];
  int exp_kind[$], exp_cyc[$], exp_data[$];
  int busy_cnt  = 0;
  int exp_busy  = 0;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CLKS),
    .DATA_BITS   (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: 1 = valid, 2 = frame_err, 3 = parity_err.
  always @(negedge clk) begin
    if (valid) begin
      ev_kind.push_back(1); ev_cyc.push_back(cyc); ev_data.push_back(int'(data)); ev_busy.push_back(int'(busy));
    end
    if (frame_err) begin
      ev_kind.push_back(2); ev_cyc.push_back(cyc); ev_data.push_back(int'(data)); ev_busy.push_back(int'(busy));
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin
      ev_kind.push_back(3); ev_cyc.push_back(cyc); ev_data.push_back(int'(data)); ev_busy.push_back(int'(busy));
    end
`endif
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) wave.push_back(1'b1);
  endtask

  task automatic low(input int n);
    repeat (n) wave.push_back(1'b0);
  endtask

  task automatic frame(input logic [31:0] d, input bit stopb);
    repeat (CLKS) wave.push_back(1'b0);
    for (int k = 0; k < DB; k++) repeat (CLKS) wave.push_back(d[k]);
`ifdef UART_RX_PARITY_EN
    repeat (CLKS) wave.push_back((^d[DB-1:0]) ^ par_flip);
`endif
    repeat (CLKS) wave.push_back(stopb);
  endtask

  // Reference decoder over the pin waveform: a UART sampled at mid-bit from
  // each accepted falling edge; rx_s trails the pin by two cycles.
  task automatic run_model();
    int i;
    int f;
    int d;
    exp_kind.delete(); exp_cyc.delete(); exp_data.delete();
    exp_busy = 0;
    i = 1;
    while (i < wave.size()) begin
      if (wave[i-1] && !wave[i]) begin
        f = i;
        if (f + HALF + 2 >= wave.size()) break;
        if (wave[f+HALF]) begin
          exp_busy += HALF;
          i = f + HALF + 1;
        end else begin
          if (f + STOP_OFF + 3 >= wave.size()) break;
          d = 0;
          for (int k = 0; k < DB; k++) if (wave[f+HALF+(k+1)*CLKS]) d |= (1 << k);
          exp_busy += STOP_OFF;
          exp_cyc.push_back(f + STOP_OFF + 3);
          if (!wave[f+STOP_OFF]) begin
            exp_kind.push_back(2); exp_data.push_back(good_data);
`ifdef UART_RX_PARITY_EN
          end else if ((^d) ^ wave[f+HALF+(DB+1)*CLKS]) begin
            exp_kind.push_back(3); exp_data.push_back(good_data);
`endif
          end else begin
            exp_kind.push_back(1); exp_data.push_back(d);
            good_data = d;
          end
          i = f + STOP_OFF + 1;
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic play(input string name, input bit chk_busy);
    run_model();
    @(posedge clk); #1;
    base = cyc;
    ev_kind.delete(); ev_cyc.delete(); ev_data.delete(); ev_busy.delete();
    busy_cnt = 0;
    foreach (wave[i]) begin
      rx = wave[i];
      @(posedge clk); #1;
    end
    chk({name, " event_count"}, ev_kind.size(), exp_kind.size());
    for (int j = 0; j < exp_kind.size(); j++) begin
      if (j < ev_kind.size()) begin
        chk($sformatf("%s ev%0d kind", name, j), ev_kind[j], exp_kind[j]);
        chk($sformatf("%s ev%0d cycle", name, j), ev_cyc[j] - base, exp_cyc[j]);
        chk($sformatf("%s ev%0d data", name, j), ev_data[j], exp_data[j]);
        chk($sformatf("%s ev%0d busy", name, j), ev_busy[j], 0);
      end
    end
    if (chk_busy) chk({name, " busy_cycles"}, busy_cnt, exp_busy);
  endtask

  task automatic do_reset(input bit rxv, input int n);
    rst = 1'b1;
    rx  = rxv;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    good_data = 0;
  endtask

  task automatic chk_idle_outputs(input string name);
    @(negedge clk);
    chk({name, " data"}, int'(data), 0);
    chk({name, " valid"}, int'(valid), 0);
    chk({name, " frame_err"}, int'(frame_err), 0);
    chk({name, " busy"}, int'(busy), 0);
  endtask

  initial begin
    // Reset state.
    do_reset(1'b1, 3);
    chk_idle_outputs("reset");

    // 0x55, good stop: valid exactly t0+153 (t0 = pin edge + 2).
    wave.delete(); idle(20); frame(32'h55, 1'b1); idle(40);
    play("frame_55", 1'b1);
    if (ev_cyc.size() > 0)
      chk("latency_55", ev_cyc[0] - base - (20 + 2), STOP_OFF + 1);

    // 4-cycle glitch: busy for HALF cycles, no pulses.
    wave.delete(); idle(10); low(4); idle(40);
    play("glitch", 1'b1);

    // 0xA3 with bad stop, then a long break, then recovery frame.
    wave.delete(); idle(10); frame(32'hA3, 1'b0); low(20 * CLKS); idle(30);
    frame(32'h3C, 1'b1); idle(40);
    play("break", 1'b1);

    // Back-to-back 0xA3, 0x0F with a single stop bit.
    wave.delete(); idle(10); frame(32'hA3, 1'b1); frame(32'h0F, 1'b1); idle(40);
    play("b2b", 1'b1);
    if (ev_cyc.size() > 1)
      chk("b2b_spacing", ev_cyc[1] - ev_cyc[0], (NB + 2) * CLKS);

    // Reset during data bit 3, then a clean 0x3C frame.
    wave.delete(); idle(10); low(CLKS);
    for (int k = 0; k < 3; k++) repeat (CLKS) wave.push_back(1'b0);
    repeat (HALF + 2) wave.push_back(1'b1);
    play("abort_part", 1'b0);
    do_reset(1'b1, 2);
    chk_idle_outputs("abort_reset");
    wave.delete(); idle(20); frame(32'h3C, 1'b1); idle(40);
    play("after_abort", 1'b1);

    // Line held low across reset release: no frame until it rises and falls.
    do_reset(1'b0, 3);
    wave.delete(); low(60); idle(20);
    play("low_at_reset", 1'b1);

`ifdef UART_RX_PARITY_EN
    wave.delete(); idle(20);
    par_flip = 1'b1; frame(32'h07, 1'b1);
    par_flip = 1'b0; idle(10); frame(32'h07, 1'b1); idle(40);
    play("parity", 1'b1);
`endif

    // Randomised mixes of frames, bad stops, glitches and short gaps.
    for (int r = 0; r < 4; r++) begin
      wave.delete(); idle(20);
      for (int n = 0; n < 8; n++) begin
        if ($urandom_range(0, 4) == 0) begin
          low($urandom_range(1, HALF));
          idle($urandom_range(3, 12));
        end else begin
`ifdef UART_RX_PARITY_EN
          par_flip = ($urandom_range(0, 3) == 0);
`endif
          frame(32'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
          idle($urandom_range(0, 12));
        end
      end
      idle(200);
      play($sformatf("random%0d", r), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
